// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding, port ids,
// arbitration modes and the tie-break helper.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  // Pick a port from the current requests; on a tie, fixed mode favours D and
  // round-robin mode favours the port that was not granted last.
  function automatic logic arb_pick(input logic req_i, input logic req_d,
                                    input logic rr_mode, input logic last);
    if (req_i && req_d)
      return rr_mode ? ~last : PORT_D;
    return req_d ? PORT_D : PORT_I;
  endfunction

endpackage

// File: rtl/mem_bank.sv
// Single-port DEPTH x DATA_W word array with byte-masked synchronous write and
// synchronous read-before-write.
module mem_bank #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 256,
  parameter bit          INIT_MEM  = 1'b0,
  parameter              INIT_FILE = "",
  localparam int unsigned MASK_W   = DATA_W / 8,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [MASK_W-1:0] i_mask,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // The read captures the word as it was before this edge's write lands.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_rdata <= r_mem[i_addr];
      if (i_we) begin
        for (int unsigned b = 0; b < MASK_W; b++) begin
          if (i_mask[b])
            r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/memory_arbiter_top.sv
// Two request/valid ports (I and D) sharing one single-port word array through
// an IDLE -> WAIT -> RESP arbiter FSM with programmable read wait states.
module memory_arbiter_top
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ARB_MODE    = ARB_FIXED,
  parameter bit          INIT_MEM    = 1'b0,
  parameter              INIT_FILE   = "",
  localparam int unsigned MASK_W     = DATA_W / 8,
  localparam int unsigned ADDR_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_request,
  input  logic              i_we_re,
  input  logic [MASK_W-1:0] i_mask,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [DATA_W-1:0] i_data_in,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_data_out,
  input  logic              d_request,
  input  logic              d_we_re,
  input  logic [MASK_W-1:0] d_mask,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_data_in,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_data_out,
  output logic              busy
);

  if ((DATA_W % 8) != 0 || DATA_W == 0 || WAIT_STATES > 15 ||
      ARB_MODE > ARB_RR || (DEPTH & (DEPTH - 1)) != 0 || DEPTH < 2) begin : g_bad_param
    $error("memory_arbiter_top: illegal parameter combination");
  end

  localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  logic [1:0]        r_state;
  logic              r_port;
  logic              r_last;
  logic [3:0]        r_wait;
  logic [DATA_W-1:0] r_i_hold;
  logic [DATA_W-1:0] r_d_hold;

  logic              w_any_req;
  logic              w_accept;
  logic              w_grant;
  logic              w_we;
  logic [MASK_W-1:0] w_mask;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;
  logic              w_resp;

  assign w_any_req = i_request | d_request;
  assign w_accept  = (r_state == ST_IDLE) && w_any_req && !rst;
  assign w_grant   = arb_pick(i_request, d_request, ARB_MODE == ARB_RR, r_last);

  always_comb begin
    w_we    = i_we_re;
    w_mask  = i_mask;
    w_addr  = i_address;
    w_wdata = i_data_in;
    if (w_grant == PORT_D) begin
      w_we    = d_we_re;
      w_mask  = d_mask;
      w_addr  = d_address;
      w_wdata = d_data_in;
    end
  end

  // The bank's read register doubles as the response latch: it is loaded only
  // on acceptance, so it holds the granted word through WAIT and RESP.
  mem_bank #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .INIT_MEM  (INIT_MEM),
    .INIT_FILE (INIT_FILE)
  ) u_bank (
    .clk     (clk),
    .i_en    (w_accept),
    .i_we    (w_we),
    .i_mask  (w_mask),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_port  <= PORT_I;
      r_last  <= PORT_I;
      r_wait  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_port <= w_grant;
            r_last <= w_grant;
            if (WAIT_STATES == 0) begin
              r_state <= ST_RESP;
            end else begin
              r_state <= ST_WAIT;
              r_wait  <= WS_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (r_wait == '0)
            r_state <= ST_RESP;
          else
            r_wait <= r_wait - 4'd1;
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_resp = (r_state == ST_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_i_hold <= '0;
      r_d_hold <= '0;
    end else if (w_resp) begin
      if (r_port == PORT_I)
        r_i_hold <= w_rdata;
      else
        r_d_hold <= w_rdata;
    end
  end

  assign i_valid    = w_resp && (r_port == PORT_I);
  assign d_valid    = w_resp && (r_port == PORT_D);
  assign i_data_out = i_valid ? w_rdata : r_i_hold;
  assign d_data_out = d_valid ? w_rdata : r_d_hold;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_memory_arbiter_top.sv
// Directed bench: three arbiter configurations share one stimulus bus; each
// sequence checks only the instance whose configuration it targets.
module tb_memory_arbiter_top;

  logic        clk;
  logic        rst;
  logic        i_request, i_we_re, d_request, d_we_re;
  logic [3:0]  i_mask, d_mask;
  logic [7:0]  i_address, d_address;
  logic [31:0] i_data_in, d_data_in;

  logic        ivo [3];
  logic        dvo [3];
  logic        bzo [3];
  logic [31:0] ido [3];
  logic [31:0] ddo [3];

  int checks = 0;
  int errors = 0;

  // dut0: fixed priority, no wait states; dut1: round-robin; dut2: 3 wait states
  memory_arbiter_top #(.WAIT_STATES(0), .ARB_MODE(0)) dut0 (
    .clk(clk), .rst(rst),
    .i_request(i_request), .i_we_re(i_we_re), .i_mask(i_mask), .i_address(i_address),
    .i_data_in(i_data_in), .i_valid(ivo[0]), .i_data_out(ido[0]),
    .d_request(d_request), .d_we_re(d_we_re), .d_mask(d_mask), .d_address(d_address),
    .d_data_in(d_data_in), .d_valid(dvo[0]), .d_data_out(ddo[0]), .busy(bzo[0]));

  memory_arbiter_top #(.WAIT_STATES(0), .ARB_MODE(1)) dut1 (
    .clk(clk), .rst(rst),
    .i_request(i_request), .i_we_re(i_we_re), .i_mask(i_mask), .i_address(i_address),
    .i_data_in(i_data_in), .i_valid(ivo[1]), .i_data_out(ido[1]),
    .d_request(d_request), .d_we_re(d_we_re), .d_mask(d_mask), .d_address(d_address),
    .d_data_in(d_data_in), .d_valid(dvo[1]), .d_data_out(ddo[1]), .busy(bzo[1]));

  memory_arbiter_top #(.WAIT_STATES(3), .ARB_MODE(0)) dut2 (
    .clk(clk), .rst(rst),
    .i_request(i_request), .i_we_re(i_we_re), .i_mask(i_mask), .i_address(i_address),
    .i_data_in(i_data_in), .i_valid(ivo[2]), .i_data_out(ido[2]),
    .d_request(d_request), .d_we_re(d_we_re), .d_mask(d_mask), .d_address(d_address),
    .d_data_in(d_data_in), .d_valid(dvo[2]), .d_data_out(ddo[2]), .busy(bzo[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        port;   // 1 = D, 0 = I
    logic        we;
    logic [3:0]  mask;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_request = 1'b0;
    d_request = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One transaction on one port of instance k, started from IDLE just after an edge.
  task automatic txn(input int k, input logic port, input logic we, input logic [3:0] mask,
                     input logic [7:0] addr, input logic [31:0] data,
                     input logic chk, input logic [31:0] exp, input string name);
    int   t;
    int   lat;
    logic seen, other, bz_bad;
    logic [31:0] got;
    lat = (k == 2) ? 4 : 1;
    if (port) begin
      d_request = 1'b1; d_we_re = we; d_mask = mask; d_address = addr; d_data_in = data;
    end else begin
      i_request = 1'b1; i_we_re = we; i_mask = mask; i_address = addr; i_data_in = data;
    end
    t = 0; seen = 1'b0; other = 1'b0; bz_bad = 1'b0; got = '0;
    while (!seen && t < 20) begin
      @(negedge clk);
      if (bzo[k] !== (t >= 1)) bz_bad = 1'b1;
      if ((port ? ivo[k] : dvo[k]) !== 1'b0) other = 1'b1;
      if ((port ? dvo[k] : ivo[k]) === 1'b1) begin
        seen = 1'b1;
        got  = port ? ddo[k] : ido[k];
      end else begin
        t++;
      end
    end
    chk_eq({name, " latency"}, t, lat);
    chk_eq({name, " other valid"}, {31'd0, other}, 32'd0);
    chk_eq({name, " busy profile"}, {31'd0, bz_bad}, 32'd0);
    if (chk) chk_eq({name, " data"}, got, exp);
    @(posedge clk);
    #1;
    if (port) d_request = 1'b0; else i_request = 1'b0;
    @(negedge clk);
    chk_eq({name, " pulse end"}, {30'd0, (port ? dvo[k] : ivo[k]), bzo[k]}, 32'd0);
    sync();
  endtask

  initial begin : main
    int t, td, ti;
    logic [31:0] gd, gi;
    logic [15:0] obs;
    logic [7:0]  obs2;
    logic        dv_bad;

    rst = 1'b1;
    i_request = 1'b0; i_we_re = 1'b0; i_mask = '0; i_address = '0; i_data_in = '0;
    d_request = 1'b0; d_we_re = 1'b0; d_mask = '0; d_address = '0; d_data_in = '0;

    vecs[0]  = '{1'b1, 1'b1, 4'hF, 8'h05, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 4'h0, 8'h05, 32'h0,        1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b1, 4'h5, 8'h05, 32'h11223344, 1'b1, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 1'b0, 4'h0, 8'h05, 32'h0,        1'b1, 32'hDE22BE44};
    vecs[4]  = '{1'b0, 1'b1, 4'hF, 8'h09, 32'h12345678, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 4'h0, 8'h09, 32'hFFFFFFFF, 1'b1, 32'h12345678};
    vecs[6]  = '{1'b0, 1'b0, 4'hF, 8'h09, 32'hAAAAAAAA, 1'b1, 32'h12345678};
    vecs[7]  = '{1'b1, 1'b0, 4'h0, 8'h09, 32'h0,        1'b1, 32'h12345678};
    vecs[8]  = '{1'b0, 1'b1, 4'hF, 8'hFF, 32'h01020304, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 4'h8, 8'hFF, 32'hAABBCCDD, 1'b1, 32'h01020304};
    vecs[10] = '{1'b0, 1'b0, 4'h0, 8'hFF, 32'h0,        1'b1, 32'hAA020304};
    vecs[11] = '{1'b1, 1'b0, 4'h3, 8'h05, 32'h0,        1'b1, 32'hDE22BE44};

    do_reset();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk_eq($sformatf("reset ctrl dut%0d", k), {29'd0, ivo[k], dvo[k], bzo[k]}, 32'd0);
      chk_eq($sformatf("reset i_data dut%0d", k), ido[k], 32'd0);
      chk_eq($sformatf("reset d_data dut%0d", k), ddo[k], 32'd0);
    end
    sync();

    // Single-port transactions on the fixed-priority, zero-wait instance
    for (int i = 0; i < 12; i++)
      txn(0, vecs[i].port, vecs[i].we, vecs[i].mask, vecs[i].addr, vecs[i].data,
          vecs[i].chk, vecs[i].exp, $sformatf("vec%0d", i));

    // Simultaneous reads, fixed priority: D first, then I two cycles later
    d_we_re = 1'b0; d_mask = '0; d_address = 8'h05;
    i_we_re = 1'b0; i_mask = '0; i_address = 8'h09;
    d_request = 1'b1; i_request = 1'b1;
    t = 0; td = -1; ti = -1; gd = '0; gi = '0;
    while ((td < 0 || ti < 0) && t < 20) begin
      @(negedge clk);
      if (dvo[0] === 1'b1 && td < 0) begin td = t; gd = ddo[0]; end
      if (ivo[0] === 1'b1 && ti < 0) begin ti = t; gi = ido[0]; end
      @(posedge clk);
      #1;
      if (td >= 0) d_request = 1'b0;
      if (ti >= 0) i_request = 1'b0;
      t++;
    end
    chk_eq("fixed tie d cycle", td, 1);
    chk_eq("fixed tie i cycle", ti, 3);
    chk_eq("fixed tie d data", gd, 32'hDE22BE44);
    chk_eq("fixed tie i data", gi, 32'h12345678);
    sync();

    // Round-robin with both ports requesting continuously
    do_reset();
    d_address = 8'h00; i_address = 8'h01;
    d_request = 1'b1; i_request = 1'b1;
    obs = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      obs[2*c +: 2] = {dvo[1], ivo[1]};
    end
    chk_eq("rr grant order", {16'd0, obs}, 32'h00004848);
    sync();
    d_request = 1'b0; i_request = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rr idle busy", {31'd0, bzo[1]}, 32'd0);
    sync();
    d_request = 1'b1; i_request = 1'b1;
    obs2 = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      obs2[2*c +: 2] = {dvo[1], ivo[1]};
    end
    chk_eq("rr pointer held", {24'd0, obs2}, 32'h00000048);
    sync();
    d_request = 1'b0; i_request = 1'b0;
    repeat (2) sync();

    // Wait-state instance: latency and busy window
    do_reset();
    txn(2, 1'b0, 1'b1, 4'hF, 8'h03, 32'hCAFEF00D, 1'b0, 32'h0, "ws3 write");
    txn(2, 1'b0, 1'b0, 4'h0, 8'h03, 32'h0, 1'b1, 32'hCAFEF00D, "ws3 read");

    // Reset during WAIT aborts the read; stored data survives
    txn(2, 1'b1, 1'b1, 4'hF, 8'h07, 32'h5A5A1234, 1'b0, 32'h0, "abort setup write");
    d_we_re = 1'b0; d_mask = '0; d_address = 8'h07; d_request = 1'b1;
    sync();
    sync();
    rst = 1'b1;
    d_request = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_eq("abort busy", {31'd0, bzo[2]}, 32'd0);
    chk_eq("abort data_out cleared", ddo[2], 32'd0);
    dv_bad = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (dvo[2] !== 1'b0) dv_bad = 1'b1;
      @(negedge clk);
    end
    chk_eq("abort no valid", {31'd0, dv_bad}, 32'd0);
    sync();
    txn(2, 1'b1, 1'b0, 4'h0, 8'h07, 32'h0, 1'b1, 32'h5A5A1234, "after abort read");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
